// File: rtl/cpu_pkg.sv
// Shared types for the CPU address path: addressing modes, sequencer states
// and the operand byte-count helper.
package cpu_pkg;

    localparam int ADDR_W = 24;

    typedef enum logic [1:0] {
        ABS    = 2'd0,
        LONG   = 2'd1,
        DP     = 2'd2,
        DP_EMU = 2'd3
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // A zero byte count still performs a single access.
    function automatic logic [1:0] clamp_nbytes(input logic [1:0] n);
        logic [1:0] r;
        if (n == 2'd0) begin
            r = 2'd1;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/addr_sequencer_ea_calc.sv
// Effective-address calculation for the CALC cycle: base+index with the
// wrap behaviour of each addressing mode.
module ea_calc
    import cpu_pkg::*;
(
    input  addr_mode_t          i_mode,
    input  logic [ADDR_W-1:0]   i_base,
    input  logic [15:0]         i_index,
    output logic [ADDR_W-1:0]   o_wdata,
    output logic                o_bank_inc
);

    logic [16:0] w_sum17;
    logic [7:0]  w_lo_emu;

    assign w_sum17  = {1'b0, i_base[15:0]} + {1'b0, i_index};
    assign w_lo_emu = i_base[7:0] + i_index[7:0];

    // Mode select: only ABS/LONG may carry into the bank byte.
    always_comb begin
        o_wdata    = {ADDR_W{1'b0}};
        o_bank_inc = 1'b0;
        case (i_mode)
            ABS, LONG: begin
                o_wdata    = {i_base[23:16], w_sum17[15:0]};
                o_bank_inc = w_sum17[16];
            end
            DP: begin
                o_wdata    = {8'h00, w_sum17[15:0]};
                o_bank_inc = 1'b0;
            end
            DP_EMU: begin
                o_wdata    = {8'h00, i_base[15:8], w_lo_emu};
                o_bank_inc = 1'b0;
            end
            default: begin
                o_wdata    = {ADDR_W{1'b0}};
                o_bank_inc = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/addr_sequencer.sv
// Drives the 24-bit address register through one operand access: effective
// address load, then 1-3 byte steps honouring bank, DP and page wrap rules.
module addr_sequencer
    import cpu_pkg::*;
#(
    parameter int MAX_BYTES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [23:0] base,
    input  logic [15:0] index,
    input  logic [1:0]  nbytes,
    output logic [23:0] addr_wdata,
    output logic [2:0]  addr_write,
    output logic        addr_inc,
    output logic        addr_page_wrap,
    output logic        addr_bank_inc,
    output logic        addr_valid,
    output logic [1:0]  byte_idx,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    seq_state_t         r_state;
    addr_mode_t         r_mode;
    logic [ADDR_W-1:0]  r_base;
    logic [15:0]        r_index;
    logic [CNT_W-1:0]   r_nbytes;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_cur_lo;

    logic [ADDR_W-1:0]  w_ea_wdata;
    logic               w_ea_bank_inc;
    logic               w_last;
    logic               w_dp_wrap;
    logic [15:0]        w_next_lo;

    ea_calc u_ea_calc (
        .i_mode     (r_mode),
        .i_base     (r_base),
        .i_index    (r_index),
        .o_wdata    (w_ea_wdata),
        .o_bank_inc (w_ea_bank_inc)
    );

    assign w_last    = (r_cnt == (r_nbytes - CNT_W'(1)));
    assign w_dp_wrap = (r_mode == DP) && (r_cur_lo == 16'hFFFF);
    // Only the low 16 bits are tracked: the bank byte matters to no step decision.
    assign w_next_lo = (r_mode == DP_EMU) ? {r_cur_lo[15:8], r_cur_lo[7:0] + 8'd1}
                                          : (r_cur_lo + 16'd1);

    // Sequencer state, latched request and internal copy of the current address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mode   <= ABS;
            r_base   <= {ADDR_W{1'b0}};
            r_index  <= 16'h0000;
            r_nbytes <= {CNT_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_cur_lo <= 16'h0000;
        end else if (cpu_en) begin
            if (abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_mode   <= addr_mode_t'(mode);
                            r_base   <= base;
                            r_index  <= index;
                            r_nbytes <= CNT_W'(clamp_nbytes(nbytes));
                            r_state  <= CALC;
                        end
                    end
                    CALC: begin
                        r_cnt    <= {CNT_W{1'b0}};
                        r_cur_lo <= w_ea_wdata[15:0];
                        r_state  <= XFER;
                    end
                    XFER: begin
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                            r_cur_lo <= w_next_lo;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Register controls decoded from state; reset and abort silence them at once.
    always_comb begin
        addr_wdata     = 24'h000000;
        addr_write     = 3'b000;
        addr_inc       = 1'b0;
        addr_page_wrap = 1'b0;
        addr_bank_inc  = 1'b0;
        addr_valid     = 1'b0;
        byte_idx       = 2'd0;
        busy           = 1'b0;
        done           = 1'b0;
        if (reset) begin
            busy = 1'b0;
        end else begin
            busy = (r_state != IDLE);
            if (abort && cpu_en) begin
                addr_valid = 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        addr_valid = 1'b0;
                    end
                    CALC: begin
                        addr_wdata    = w_ea_wdata;
                        addr_write    = 3'b111;
                        addr_bank_inc = w_ea_bank_inc;
                    end
                    XFER: begin
                        addr_valid = 1'b1;
                        byte_idx   = 2'(r_cnt);
                        if (w_last) begin
                            addr_inc = 1'b0;
                        end else if (w_dp_wrap) begin
                            addr_write = 3'b011;
                            addr_wdata = 24'h000000;
                        end else begin
                            addr_inc       = 1'b1;
                            addr_page_wrap = (r_mode == DP_EMU);
                        end
                    end
                    DONE: begin
                        done = 1'b1;
                    end
                    default: begin
                        addr_valid = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer: an independent address-register model
// replays the emitted controls and the observed addresses are compared.
module tb_addr_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, cpu_en, start, abort;
    logic [1:0]  mode, nbytes;
    logic [23:0] base;
    logic [15:0] index;
    logic [23:0] addr_wdata;
    logic [2:0]  addr_write;
    logic        addr_inc, addr_page_wrap, addr_bank_inc, addr_valid;
    logic [1:0]  byte_idx;
    logic        busy, done;

    addr_sequencer dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .start(start), .abort(abort),
        .mode(mode), .base(base), .index(index), .nbytes(nbytes),
        .addr_wdata(addr_wdata), .addr_write(addr_write), .addr_inc(addr_inc),
        .addr_page_wrap(addr_page_wrap), .addr_bank_inc(addr_bank_inc),
        .addr_valid(addr_valid), .byte_idx(byte_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [23:0] model_reg;
    logic [23:0] obs_addr [4];
    logic [1:0]  obs_idx  [4];
    int n_obs, busy_cnt, done_cnt, inc_cnt, pw_cnt, dpw_cnt, excl_viol, ec;
    int first_valid_ec, last_valid_ec, done_ec;
    logic [23:0] calc_wdata;
    logic        calc_bank;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {29'd0, addr_wdata, addr_write, addr_inc, addr_page_wrap, addr_bank_inc,
                addr_valid, byte_idx, busy, done};
    endfunction

    task automatic clear_stats();
        n_obs = 0; busy_cnt = 0; done_cnt = 0; inc_cnt = 0; pw_cnt = 0; dpw_cnt = 0;
        excl_viol = 0; ec = 0; first_valid_ec = -1; last_valid_ec = -1; done_ec = -1;
        calc_wdata = 24'h0; calc_bank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs_addr[i] = 24'h0;
            obs_idx[i]  = 2'd0;
        end
    endtask

    // One clock: observe at negedge, replay controls into the register model on enabled cycles.
    task automatic tick(output bit saw_done);
        saw_done = 1'b0;
        @(negedge clk);
        if (cpu_en) begin
            if ((addr_write != 3'b000) && addr_inc) excl_viol++;
            if (addr_valid) begin
                if (n_obs < 4) begin
                    obs_addr[n_obs] = model_reg;
                    obs_idx[n_obs]  = byte_idx;
                end
                if (first_valid_ec < 0) first_valid_ec = ec;
                last_valid_ec = ec;
                n_obs++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_ec  = ec;
                saw_done = 1'b1;
            end
            if (addr_write == 3'b111) begin
                calc_wdata = addr_wdata;
                calc_bank  = addr_bank_inc;
            end
            if (addr_write == 3'b011 && addr_wdata == 24'h0) dpw_cnt++;
            if (addr_inc) inc_cnt++;
            if (addr_inc && addr_page_wrap) pw_cnt++;
            for (int b = 0; b < 3; b++) begin
                if (addr_write[b]) model_reg[b*8 +: 8] = addr_wdata[b*8 +: 8];
            end
            if (addr_bank_inc) model_reg[23:16] = model_reg[23:16] + 8'd1;
            if (addr_inc) begin
                if (addr_page_wrap) model_reg[7:0] = model_reg[7:0] + 8'd1;
                else                model_reg      = model_reg + 24'd1;
            end
            ec++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic [1:0] m, input logic [23:0] b, input logic [15:0] ix,
                             input logic [1:0] nb, input int period);
        bit fin, d;
        clear_stats();
        fin = 1'b0;
        mode = m; base = b; index = ix; nbytes = nb; start = 1'b1;
        for (int k = 0; k < 200 && !fin; k++) begin
            cpu_en = ((k % period) == 0);
            tick(d);
            if (d) fin = 1'b1;
            if (cpu_en) start = 1'b0;
        end
        cpu_en = 1'b1;
        check_val("done_seen", 64'(fin), 64'd1);
    endtask

    task automatic check_access(input string tag, input int nexp, input logic [23:0] a0,
                                input logic [23:0] a1, input logic [23:0] a2);
        logic [23:0] exp_a [3];
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
        check_val({tag, "_nbytes"}, 64'(n_obs), 64'(nexp));
        for (int i = 0; i < nexp; i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[i]), 64'(exp_a[i]));
            check_val($sformatf("%s_idx%0d", tag, i), 64'(obs_idx[i]), 64'(i));
        end
        check_val({tag, "_busy"}, 64'(busy_cnt), 64'(nexp + 2));
        check_val({tag, "_done"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_lat_first"}, 64'(first_valid_ec), 64'd2);
        check_val({tag, "_lat_done"}, 64'(done_ec - last_valid_ec), 64'd1);
        check_val({tag, "_excl"}, 64'(excl_viol), 64'd0);
    endtask

    initial begin
        bit d;
        model_reg = 24'h0;
        reset = 1'b1; cpu_en = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 2'd0; base = 24'h0; index = 16'h0; nbytes = 2'd0;
        clear_stats();
        @(negedge clk);
        check_val("reset_outs", all_outs(), 64'd0);
        tick(d); tick(d);
        reset = 1'b0;
        tick(d);
        @(negedge clk);
        check_val("idle_outs", all_outs(), 64'd0);
        @(posedge clk); #1;

        // ABS with bank carry out of base+index
        do_access(2'(ABS), 24'h7EFFFE, 16'h0003, 2'd2, 1);
        check_val("abs_calc_wdata", 64'(calc_wdata), 64'h7E0001);
        check_val("abs_calc_bank", 64'(calc_bank), 64'd1);
        check_val("abs_inc", 64'(inc_cnt), 64'd1);
        check_val("abs_pw", 64'(pw_cnt), 64'd0);
        check_access("abs", 2, 24'h7F0001, 24'h7F0002, 24'h0);

        // DP wraps inside bank 0 via a low-word write
        do_access(2'(DP), 24'h00FFF0, 16'h000F, 2'd2, 1);
        check_val("dp_wrapwrite", 64'(dpw_cnt), 64'd1);
        check_val("dp_inc", 64'(inc_cnt), 64'd0);
        check_access("dp", 2, 24'h00FFFF, 24'h000000, 24'h0);

        // DP_EMU stays in the direct page
        do_access(2'(DP_EMU), 24'h0001FE, 16'h0001, 2'd3, 1);
        check_val("emu_pw", 64'(pw_cnt), 64'd2);
        check_val("emu_inc", 64'(inc_cnt), 64'd2);
        check_access("emu", 3, 24'h0001FF, 24'h000100, 24'h000101);

        // LONG carries across the bank on increment
        do_access(2'(LONG), 24'h12FFFF, 16'h0000, 2'd3, 1);
        check_val("long_calc_bank", 64'(calc_bank), 64'd0);
        check_access("long", 3, 24'h12FFFF, 24'h130000, 24'h130001);

        // cpu_en high one cycle in three
        do_access(2'(ABS), 24'h7EFFFE, 16'h0003, 2'd2, 3);
        check_access("abs_en3", 2, 24'h7F0001, 24'h7F0002, 24'h0);

        // nbytes = 0 behaves as 1
        do_access(2'(ABS), 24'h000010, 16'h0000, 2'd0, 1);
        check_access("nb0", 1, 24'h000010, 24'h0, 24'h0);

        // abort after byte 0
        clear_stats();
        mode = 2'(ABS); base = 24'h7EFFFE; index = 16'h0003; nbytes = 2'd3; start = 1'b1;
        tick(d); start = 1'b0;
        tick(d); tick(d);
        abort = 1'b1;
        @(negedge clk);
        check_val("abort_ctrl", {56'd0, addr_write, addr_inc, addr_page_wrap, addr_bank_inc,
                                  addr_valid, done}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        tick(d); tick(d);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_nobytes", 64'(n_obs), 64'd1);
        check_val("abort_nodone", 64'(done_cnt), 64'd0);

        // reset while in CALC
        mode = 2'(ABS); base = 24'h123456; index = 16'h0001; nbytes = 2'd1; start = 1'b1;
        tick(d); start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_calc_outs", all_outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_after_outs", all_outs(), 64'd0);
        @(posedge clk); #1;

        // start held through DONE is only taken back in IDLE
        mode = 2'(ABS); base = 24'h000100; index = 16'h0000; nbytes = 2'd1; start = 1'b1;
        tick(d); tick(d); tick(d);
        @(negedge clk);
        check_val("sd_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("sd_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("sd_restart", 64'(addr_write), 64'd7);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
